// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences one rendered frame (clear, draw, drain, buffer swap) between the math pipeline pixel stream and the framebuffer write port.
// Latency: a pixel accepted in cycle N is presented on fb_wr in cycle N+1. The clear pass issues one write per cycle starting the cycle after frame_start.
// Backpressure: pixel_s_ready is low whenever a write is pending and fb_wr_ready is low. fb_wr_addr/fb_wr_data hold until the handshake. swap_req holds until swap_ack.
//
// Build option: FRAME_SCHED_CLEAR_EN
//   defined   -> frame_start enters CLEAR, which writes CLEAR_COLOR to every address before DRAW.
//   undefined -> frame_start enters DRAW directly, and the old buffer contents persist.
//
// Ports:
//   clk, rst                    single clock; synchronous active-high reset
//   frame_start, frame_end      one-cycle strobes from the command head
//   math_idle                   math pipeline holds no in-flight work
//   pixel_s_*                   rasterized pixel stream in (valid/ready, x, y, color)
//   fb_wr_*                     framebuffer write stream out (valid/ready, linear addr, data)
//   swap_req / swap_ack         buffer swap handshake with the display side
//   busy, frame_done            status: frame in progress, one-cycle pulse on swap completion
//   frame_count                 completed frames, wraps at 16 bits
module frame_scheduler #(
  parameter int                 BUFFER_WIDTH  = 160,
  parameter int                 BUFFER_HEIGHT = 120,
  parameter int                 COLOR_W       = 12,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR   = 12'h000,
  localparam int                XW            = $clog2(BUFFER_WIDTH),
  localparam int                YW            = $clog2(BUFFER_HEIGHT),
  localparam int                ADDR_W        = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               math_idle,
  input  logic               pixel_s_valid,
  output logic               pixel_s_ready,
  input  logic [XW-1:0]      pixel_s_x,
  input  logic [YW-1:0]      pixel_s_y,
  input  logic [COLOR_W-1:0] pixel_s_color,
  output logic               fb_wr_valid,
  input  logic               fb_wr_ready,
  output logic [ADDR_W-1:0]  fb_wr_addr,
  output logic [COLOR_W-1:0] fb_wr_data,
  output logic               swap_req,
  input  logic               swap_ack,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRAW  = 3'd2,
    DRAIN = 3'd3,
    SWAP  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(BUFFER_WIDTH);

  state_t state;
  logic   end_seen;
  logic   accepting;   // DRAW or DRAIN: the pixel stream may be admitted

  logic              pix_acc;
  logic              pix_in_range;
  logic [ADDR_W-1:0] pix_addr;

  // Ready only frees up when the output register is empty or draining this cycle.
  assign pixel_s_ready = accepting && (!fb_wr_valid || fb_wr_ready);
  assign pix_acc       = pixel_s_valid && pixel_s_ready;

  // Coordinates are $clog2 wide, so out-of-range values exist only for non-power-of-two sizes.
  assign pix_in_range = (32'(pixel_s_x) < 32'(BUFFER_WIDTH)) &&
                        (32'(pixel_s_y) < 32'(BUFFER_HEIGHT));

  // For in-range pixels, y*W+x < W*H, so the result fits in ADDR_W bits.
  assign pix_addr = ADDR_W'(pixel_s_y) * WIDTH_A + ADDR_W'(pixel_s_x);

`ifdef FRAME_SCHED_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUFFER_WIDTH*BUFFER_HEIGHT - 1);
`else
  logic unused_clear_color;
  assign unused_clear_color = ^CLEAR_COLOR;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      end_seen    <= 1'b0;
      accepting   <= 1'b0;
      fb_wr_valid <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      swap_req    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            busy     <= 1'b1;
            end_seen <= 1'b0;
`ifdef FRAME_SCHED_CLEAR_EN
            // fb_wr_addr doubles as the clear counter.
            state       <= CLEAR;
            fb_wr_valid <= 1'b1;
            fb_wr_addr  <= '0;
            fb_wr_data  <= CLEAR_COLOR;
`else
            state     <= DRAW;
            accepting <= 1'b1;
`endif
          end
        end

`ifdef FRAME_SCHED_CLEAR_EN
        CLEAR: begin
          // A frame_end that arrives during the clear is remembered until DRAW.
          if (frame_end) end_seen <= 1'b1;
          // fb_wr_valid is held high for the whole clear, so ready alone is the handshake.
          if (fb_wr_ready) begin
            if (fb_wr_addr == LAST_ADDR) begin
              state       <= DRAW;
              accepting   <= 1'b1;
              fb_wr_valid <= 1'b0;
            end else begin
              fb_wr_addr <= fb_wr_addr + 1'b1;
            end
          end
        end
`endif

        DRAW, DRAIN: begin
          if (fb_wr_valid && fb_wr_ready) fb_wr_valid <= 1'b0;
          // Out-of-range pixels are consumed from the stream but produce no write.
          if (pix_acc && pix_in_range) begin
            fb_wr_valid <= 1'b1;
            fb_wr_addr  <= pix_addr;
            fb_wr_data  <= pixel_s_color;
          end

          if (state == DRAW) begin
            if (frame_end) end_seen <= 1'b1;
            if (end_seen)  state    <= DRAIN;
          end else if (math_idle && !pixel_s_valid && !fb_wr_valid) begin
            // Nothing upstream, nothing on the stream, nothing pending: the frame is complete.
            state     <= SWAP;
            accepting <= 1'b0;
            swap_req  <= 1'b1;
          end
        end

        SWAP: begin
          if (swap_ack) begin
            state       <= IDLE;
            swap_req    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end

        default: begin
          state       <= IDLE;
          accepting   <= 1'b0;
          fb_wr_valid <= 1'b0;
          swap_req    <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed bench for frame_scheduler with a small 5x3 buffer.
// The 5x3 size is chosen because coordinate widths are $clog2 of the dimensions, so with 5x3 the values x=5..7 and y=3 can be driven as out-of-range pixels.
// Both builds are handled: with FRAME_SCHED_CLEAR_EN, a 15-write clear pass precedes DRAW.
module tb_frame_scheduler;

  localparam int              W  = 5;
  localparam int              H  = 3;
  localparam logic [11:0]     CC = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst, frame_start, frame_end, math_idle;
  logic        pixel_s_valid, pixel_s_ready;
  logic [2:0]  pixel_s_x;
  logic [1:0]  pixel_s_y;
  logic [11:0] pixel_s_color;
  logic        fb_wr_valid, fb_wr_ready;
  logic [3:0]  fb_wr_addr;
  logic [11:0] fb_wr_data;
  logic        swap_req, swap_ack, busy, frame_done;
  logic [15:0] frame_count;

  int nv = 0;
  int nm = 0;

  always #5 clk = ~clk;

  frame_scheduler #(
    .BUFFER_WIDTH (W),
    .BUFFER_HEIGHT(H),
    .COLOR_W      (12),
    .CLEAR_COLOR  (CC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .math_idle    (math_idle),
    .pixel_s_valid(pixel_s_valid),
    .pixel_s_ready(pixel_s_ready),
    .pixel_s_x    (pixel_s_x),
    .pixel_s_y    (pixel_s_y),
    .pixel_s_color(pixel_s_color),
    .fb_wr_valid  (fb_wr_valid),
    .fb_wr_ready  (fb_wr_ready),
    .fb_wr_addr   (fb_wr_addr),
    .fb_wr_data   (fb_wr_data),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_count  (frame_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nv++; if (pixel_s_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", pixel_s_ready); nm++; end
    nv++; if (fb_wr_valid !== 1'b0) begin $display("FAIL reset_wr_valid: got %b want 0", fb_wr_valid); nm++; end
    nv++; if (fb_wr_addr !== 4'd0 || fb_wr_data !== 12'h000) begin $display("FAIL reset_addr_data: got %h/%h want 0/000", fb_wr_addr, fb_wr_data); nm++; end
    nv++; if (swap_req !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin $display("FAIL reset_status: got swap_req=%b busy=%b done=%b want 0 0 0", swap_req, busy, frame_done); nm++; end
    nv++; if (frame_count !== 16'd0) begin $display("FAIL reset_count: got %0d want 0", frame_count); nm++; end
  endtask

  // Starts frame 1 and leaves it in DRAW/DRAIN with frame_end already registered.
  task automatic test_clear();
    fb_wr_ready = 1'b1;
    pulse_start();
    nv++; if (busy !== 1'b1) begin $display("FAIL start_busy: got %b want 1", busy); nm++; end
`ifdef FRAME_SCHED_CLEAR_EN
    for (int i = 0; i < W*H; i++) begin
      frame_end = (i == 5);
      nv++;
      if (fb_wr_valid !== 1'b1 || fb_wr_addr !== 4'(i) || fb_wr_data !== CC) begin
        $display("FAIL clear_write_%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h", i, fb_wr_valid, fb_wr_addr, fb_wr_data, i, CC);
        nm++;
      end
      step();
    end
    frame_end = 1'b0;
    nv++; if (fb_wr_valid !== 1'b0 || pixel_s_ready !== 1'b1) begin $display("FAIL clear_to_draw: got v=%b ready=%b want v=0 ready=1", fb_wr_valid, pixel_s_ready); nm++; end
`else
    nv++; if (fb_wr_valid !== 1'b0 || pixel_s_ready !== 1'b1) begin $display("FAIL start_draw: got v=%b ready=%b want v=0 ready=1", fb_wr_valid, pixel_s_ready); nm++; end
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
`endif
  endtask

  task automatic test_pixel_stall();
    fb_wr_ready   = 1'b0;
    pixel_s_valid = 1'b1;
    pixel_s_x     = 3'd3;
    pixel_s_y     = 2'd1;
    pixel_s_color = 12'hABC;
    #1;
    nv++; if (pixel_s_ready !== 1'b1) begin $display("FAIL pix_ready_idle: got %b want 1", pixel_s_ready); nm++; end
    step();
    // A second pixel waits on the stream while the first write is stalled.
    pixel_s_x     = 3'd0;
    pixel_s_y     = 2'd0;
    pixel_s_color = 12'h111;
    for (int k = 0; k < 3; k++) begin
      nv++;
      if (fb_wr_valid !== 1'b1 || fb_wr_addr !== 4'd8 || fb_wr_data !== 12'hABC || pixel_s_ready !== 1'b0) begin
        $display("FAIL pix_stall_%0d: got v=%b a=%0d d=%h rdy=%b want v=1 a=8 d=abc rdy=0", k, fb_wr_valid, fb_wr_addr, fb_wr_data, pixel_s_ready);
        nm++;
      end
      step();
    end
    fb_wr_ready = 1'b1;
    #1;
    nv++; if (pixel_s_ready !== 1'b1) begin $display("FAIL pix_ready_release: got %b want 1", pixel_s_ready); nm++; end
    step();
    pixel_s_valid = 1'b0;
    nv++; if (fb_wr_valid !== 1'b1 || fb_wr_addr !== 4'd0 || fb_wr_data !== 12'h111) begin $display("FAIL pix_second: got v=%b a=%0d d=%h want v=1 a=0 d=111", fb_wr_valid, fb_wr_addr, fb_wr_data); nm++; end
    step();
    nv++; if (fb_wr_valid !== 1'b0) begin $display("FAIL pix_empty: got %b want 0", fb_wr_valid); nm++; end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  xs [3] = '{3'd0, 3'd4, 3'd1};
    logic [1:0]  ys [3] = '{2'd0, 2'd2, 2'd2};
    logic [3:0]  as [3] = '{4'd0, 4'd14, 4'd11};
    fb_wr_ready   = 1'b1;
    pixel_s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pixel_s_x     = xs[i];
      pixel_s_y     = ys[i];
      pixel_s_color = 12'(i + 1);
      step();
      nv++;
      if (fb_wr_valid !== 1'b1 || fb_wr_addr !== as[i] || fb_wr_data !== 12'(i + 1)) begin
        $display("FAIL b2b_%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h", i, fb_wr_valid, fb_wr_addr, fb_wr_data, as[i], 12'(i + 1));
        nm++;
      end
    end
    pixel_s_valid = 1'b0;
    step();
    nv++; if (fb_wr_valid !== 1'b0) begin $display("FAIL b2b_end: got %b want 0", fb_wr_valid); nm++; end
  endtask

  task automatic test_out_of_range();
    logic [2:0] xs [3] = '{3'd5, 3'd0, 3'd7};
    logic [1:0] ys [3] = '{2'd0, 2'd3, 2'd3};
    for (int i = 0; i < 3; i++) begin
      pixel_s_valid = 1'b1;
      pixel_s_x     = xs[i];
      pixel_s_y     = ys[i];
      pixel_s_color = 12'hFFF;
      #1;
      nv++; if (pixel_s_ready !== 1'b1) begin $display("FAIL oor_ready_%0d: got %b want 1", i, pixel_s_ready); nm++; end
      step();
      pixel_s_valid = 1'b0;
      nv++; if (fb_wr_valid !== 1'b0) begin $display("FAIL oor_drop_%0d: got %b want 0", i, fb_wr_valid); nm++; end
    end
  endtask

  task automatic test_drain_swap();
    for (int k = 0; k < 5; k++) begin
      step();
      nv++; if (swap_req !== 1'b0) begin $display("FAIL drain_hold_%0d: got %b want 0", k, swap_req); nm++; end
    end
    // math_idle alone is not enough while a pixel is still on the stream.
    math_idle     = 1'b1;
    pixel_s_valid = 1'b1;
    pixel_s_x     = 3'd6;
    pixel_s_y     = 2'd0;
    step();
    pixel_s_valid = 1'b0;
    nv++; if (swap_req !== 1'b0) begin $display("FAIL drain_pix_pending: got %b want 0", swap_req); nm++; end
    step();
    nv++; if (swap_req !== 1'b1 || busy !== 1'b1) begin $display("FAIL swap_enter: got req=%b busy=%b want 1 1", swap_req, busy); nm++; end
    for (int k = 0; k < 2; k++) begin
      step();
      nv++; if (swap_req !== 1'b1 || frame_done !== 1'b0) begin $display("FAIL swap_wait_%0d: got req=%b done=%b want 1 0", k, swap_req, frame_done); nm++; end
    end
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    nv++; if (busy !== 1'b0 || frame_done !== 1'b1 || swap_req !== 1'b0) begin $display("FAIL swap_done: got busy=%b done=%b req=%b want 0 1 0", busy, frame_done, swap_req); nm++; end
    nv++; if (frame_count !== 16'd1) begin $display("FAIL frame_count_1: got %0d want 1", frame_count); nm++; end
    step();
    nv++; if (frame_done !== 1'b0) begin $display("FAIL done_single_pulse: got %b want 0", frame_done); nm++; end
    // A stray ack while no swap is requested must not complete anything.
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    nv++; if (frame_count !== 16'd1 || frame_done !== 1'b0 || busy !== 1'b0) begin $display("FAIL stray_ack: got cnt=%0d done=%b busy=%b want 1 0 0", frame_count, frame_done, busy); nm++; end
  endtask

  task automatic test_reset_mid_frame();
    fb_wr_ready = 1'b1;
    pulse_start();
`ifdef FRAME_SCHED_CLEAR_EN
    step();
`else
    fb_wr_ready   = 1'b0;
    pixel_s_valid = 1'b1;
    pixel_s_x     = 3'd3;
    pixel_s_y     = 2'd1;
    step();
    pixel_s_valid = 1'b0;
`endif
    nv++; if (fb_wr_valid !== 1'b1) begin $display("FAIL midrst_pending: got %b want 1", fb_wr_valid); nm++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nv++; if (fb_wr_valid !== 1'b0 || fb_wr_addr !== 4'd0 || fb_wr_data !== 12'h000) begin $display("FAIL midrst_write: got v=%b a=%0d d=%h want 0 0 000", fb_wr_valid, fb_wr_addr, fb_wr_data); nm++; end
    nv++; if (busy !== 1'b0 || pixel_s_ready !== 1'b0 || swap_req !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'd0) begin
      $display("FAIL midrst_status: got busy=%b rdy=%b req=%b done=%b cnt=%0d want 0 0 0 0 0", busy, pixel_s_ready, swap_req, frame_done, frame_count);
      nm++;
    end
    fb_wr_ready = 1'b1;
    step();
    nv++; if (busy !== 1'b0 || fb_wr_valid !== 1'b0) begin $display("FAIL midrst_idle: got busy=%b v=%b want 0 0", busy, fb_wr_valid); nm++; end
  endtask

  task automatic test_wrap();
    force dut.frame_count = 16'hFFFF;
    step();
    release dut.frame_count;
    step();
    nv++; if (frame_count !== 16'hFFFF) begin $display("FAIL wrap_preload: got %h want ffff", frame_count); nm++; end
    fb_wr_ready = 1'b1;
    math_idle   = 1'b1;
    pulse_start();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    for (int i = 0; i < 100 && swap_req !== 1'b1; i++) step();
    nv++; if (swap_req !== 1'b1) begin $display("FAIL wrap_swap_timeout: got req=%b want 1", swap_req); nm++; end
    swap_ack = 1'b1;
    step();
    swap_ack = 1'b0;
    nv++; if (frame_count !== 16'd0 || frame_done !== 1'b1) begin $display("FAIL wrap_count: got cnt=%h done=%b want 0000 1", frame_count, frame_done); nm++; end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; math_idle = 1'b0;
    pixel_s_valid = 1'b0; pixel_s_x = '0; pixel_s_y = '0; pixel_s_color = '0;
    fb_wr_ready = 1'b0; swap_ack = 1'b0;
    test_reset();
    test_clear();
    test_pixel_stall();
    test_back_to_back();
    test_out_of_range();
    test_drain_swap();
    test_reset_mid_frame();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences per-frame rendering between the math pipeline's pixel stream and the framebuffer write port. It clears the back buffer, then admits rasterized pixels as framebuffer writes. After the last triangle it waits for the math pipeline to drain, then requests a buffer swap from the display side. It sits between the math pipeline's pixel output and the framebuffer/VGA tail, and takes frame start/end strobes from the command head.

## Interface
- BUFFER_WIDTH, 160, framebuffer width in pixels
- BUFFER_HEIGHT, 120, framebuffer height in pixels
- COLOR_W, 12, pixel colour width
- CLEAR_COLOR, 12'h000, colour written during clear
- Derived, not overridable: XW = $clog2(BUFFER_WIDTH), YW = $clog2(BUFFER_HEIGHT), ADDR_W = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle strobe from head: begin a frame
- frame_end  in  1  one-cycle strobe from head: last triangle issued
- math_idle  in  1  high when the math pipeline holds no in-flight work
- pixel_s_valid  in  1  pixel stream valid
- pixel_s_ready  out  1  pixel stream ready
- pixel_s_x  in  XW  pixel x
- pixel_s_y  in  YW  pixel y
- pixel_s_color  in  COLOR_W  pixel colour
- fb_wr_valid  out  1  framebuffer write valid
- fb_wr_ready  in  1  framebuffer write ready
- fb_wr_addr  out  ADDR_W  linear address y*BUFFER_WIDTH+x
- fb_wr_data  out  COLOR_W  write colour
- swap_req  out  1  buffer swap request, held until acknowledged
- swap_ack  in  1  swap accepted (display at vblank)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on swap completion
- frame_count  out  16  completed frames; wraps

## Operation
- States: IDLE, CLEAR, DRAW, DRAIN, SWAP.
- IDLE: frame_start -> CLEAR, with the clear counter set to 0 and end_seen set to 0. All other inputs are ignored. pixel_s_ready=0.
- CLEAR: issues writes of CLEAR_COLOR to addresses 0..W*H-1, one per fb_wr handshake. The handshake at address W*H-1 -> DRAW. pixel_s_ready=0.
- DRAW: pixel_s_ready = !fb_wr_valid || fb_wr_ready.
  - An accepted pixel loads fb_wr_addr/fb_wr_data and sets fb_wr_valid on the next cycle.
  - A pixel with x>=BUFFER_WIDTH or y>=BUFFER_HEIGHT is accepted but dropped; no write is issued.
  - When end_seen is set -> DRAIN.
- end_seen: a sticky flag set by frame_end in CLEAR or DRAW, so a frame_end that arrives during CLEAR is honoured on entry to DRAW. It is cleared on entering CLEAR.
- DRAIN: pixels are accepted exactly as in DRAW. Exit to SWAP when math_idle=1, pixel_s_valid=0 and fb_wr_valid=0 in the same cycle.
- SWAP: swap_req=1. A cycle with swap_req && swap_ack -> IDLE, with frame_done=1 on the following cycle and frame_count+1 (16'hFFFF wraps to 0).
- frame_start outside IDLE is ignored; it is not queued.
- fb_wr_addr uses ADDR_W-bit arithmetic. y*BUFFER_WIDTH is a constant multiply and must not overflow for in-range coordinates.
- fb_wr_addr/fb_wr_data are held stable while fb_wr_valid && !fb_wr_ready.

## Timing
- Reset values:
  - state=IDLE
  - pixel_s_ready=0, fb_wr_valid=0, fb_wr_addr=0, fb_wr_data=0
  - swap_req=0, busy=0, frame_done=0, frame_count=0
  - end_seen=0
- Reset mid-frame drops any pending write and returns to IDLE next cycle; frame_count resets to 0.
- Latency: pixel accept (cycle N) -> fb_wr_valid at N+1.
- Throughput: 1 write/cycle when fb_wr_ready is held high, in both CLEAR and DRAW.
- Clear duration with fb_wr_ready=1: W*H cycles. First clear write is valid in the cycle after frame_start is sampled.
- busy rises the cycle after frame_start and falls the cycle after the swap_ack handshake. frame_done is coincident with busy falling.
- swap_ack while swap_req=0 has no effect.
- fb_wr_valid never drops without a handshake (AXI-stream rule).

## Configuration
- FRAME_SCHED_CLEAR_EN defined: CLEAR state present, as described above.
- Not defined: the clear counter and the CLEAR state are removed; frame_start goes IDLE -> DRAW directly, and end_seen is set only in DRAW. The old buffer contents persist.

## Test plan
- Clear:
  - Stimulus: W=4, H=2, fb_wr_ready=1; pulse frame_start.
  - Required: 8 writes, addr 0..7, data CLEAR_COLOR, back-to-back; state DRAW after the 8th.
- Pixel path:
  - Stimulus: in DRAW, pixel x=3, y=1, color 12'hABC, with fb_wr_ready low for 3 cycles.
  - Required: addr=7, data held stable for 3 cycles; pixel_s_ready=0 while stalled.
- Out-of-range:
  - Stimulus: x=4, y=0 with W=4.
  - Required: accepted, no fb_wr_valid.
- Drain/swap:
  - Stimulus: frame_end pulse during CLEAR; math_idle=0 for 5 cycles, then 1; swap_ack 3 cycles after swap_req.
  - Required: DRAW -> DRAIN -> SWAP; one frame_done pulse; frame_count=1.
- Reset:
  - Stimulus: rst mid-CLEAR with fb_wr_valid=1.
  - Required: next cycle all outputs at reset values, state IDLE.
- Wrap:
  - Stimulus: force frame_count=16'hFFFF and complete a frame.
  - Required: frame_count=0.
